debounce_multi: RTL and testbench



---
 rtl/debounce_multi_if.sv | 30 +++
 rtl/debounce_multi.sv | 84 ++++++++
 tb/tb_debounce_multi.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_multi_if.sv
// Bundle of sample strobe, raw inputs and debounced outputs for debounce_multi.
// The master drives the raw pins and strobe; the slave (the debouncer) returns clean levels and events.
interface debounce_multi_if #(
  parameter int CH = 4
);
  logic          sample_en;
  logic [CH-1:0] data_in;
  logic [CH-1:0] data_out;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] long_press;

  modport master (
    output sample_en,
    output data_in,
    input  data_out,
    input  rise,
    input  fall,
    input  long_press
  );

  modport slave (
    input  sample_en,
    input  data_in,
    output data_out,
    output rise,
    output fall,
    output long_press
  );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel synchroniser, stability counter, rise/fall pulses and long-press detection.
// Every output is registered, so nothing in data_in reaches an output combinationally.
module debounce_multi #(
  parameter int CH          = 4,
  parameter int CNT_W       = 16,
  parameter int STABLE_CNT  = 1000,
  parameter int LONG_CNT    = 50000,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_LEVEL  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  debounce_multi_if.slave  bus
);

  localparam logic             IDLE_LEVEL   = INIT_LEVEL;
  localparam logic             ACTIVE_LEVEL = ~INIT_LEVEL;
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST    = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_FULL    = CNT_W'(LONG_CNT);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       hold_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   long_q;
    logic                   s;
    logic                   differ;
    logic                   accept;

    assign s      = sync_q[SYNC_STAGES-1];
    assign differ = (s != level_q);
    assign accept = bus.sample_en && differ && (cnt_q == STABLE_LAST);

    // The release edge clears the hold counter ahead of any increment, so a
    // release that coincides with the long-press threshold produces no pulse.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
        cnt_q   <= '0;
        hold_q  <= '0;
        level_q <= IDLE_LEVEL;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.data_in[g]};
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        long_q <= 1'b0;
        if (bus.sample_en) begin
          if (!differ) begin
            cnt_q <= '0;
          end else if (accept) begin
            cnt_q   <= '0;
            level_q <= s;
            rise_q  <= s;
            fall_q  <= ~s;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end

          if (accept && (s == IDLE_LEVEL)) begin
            hold_q <= '0;
          end else if ((level_q == ACTIVE_LEVEL) && (hold_q != LONG_FULL)) begin
            hold_q <= hold_q + 1'b1;
            if (hold_q == LONG_LAST) begin
              long_q <= 1'b1;
            end
          end
        end
      end
    end

    assign bus.data_out[g]   = level_q;
    assign bus.rise[g]       = rise_q;
    assign bus.fall[g]       = fall_q;
    assign bus.long_press[g] = long_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (CH=2, STABLE_CNT=8, LONG_CNT=20) with a window-based reference model
// compared every cycle, plus hand-computed latency expectations.
module tb_debounce_multi;

  localparam int CH     = 2;
  localparam int STABLE = 8;
  localparam int LONG   = 20;
  localparam int SYNC   = 2;
  localparam bit INIT   = 1'b1;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_LONG = 2;

  logic clk = 1'b0;
  logic reset;

  int n_compared   = 0;
  int n_mismatched = 0;

  debounce_multi_if #(.CH(CH)) bus ();

  debounce_multi #(
    .CH(CH),
    .CNT_W(16),
    .STABLE_CNT(STABLE),
    .LONG_CNT(LONG),
    .SYNC_STAGES(SYNC),
    .INIT_LEVEL(INIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: an input accepted after STABLE consecutive sampled values
  // all disagree with the current level; long press counted in sampled edges.
  logic [CH-1:0] in_hist[$];
  logic [CH-1:0] samp_hist[$];
  logic [CH-1:0] m_out, m_rise, m_fall, m_long;
  logic [CH-1:0] m_s, m_prev;
  int            sample_no;
  int            active_at[CH];
  bit            model_valid = 1'b0;
  bit            all_diff;

  always @(posedge clk) begin
    if (reset) begin
      in_hist.delete();
      for (int i = 0; i < SYNC; i++) in_hist.push_back({CH{INIT}});
      samp_hist.delete();
      m_out       = {CH{INIT}};
      m_rise      = '0;
      m_fall      = '0;
      m_long      = '0;
      sample_no   = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m_s = in_hist[in_hist.size() - SYNC];
      in_hist.push_back(bus.data_in);
      if (in_hist.size() > SYNC) void'(in_hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      m_long = '0;
      if (bus.sample_en) begin
        sample_no++;
        samp_hist.push_back(m_s);
        if (samp_hist.size() > STABLE) void'(samp_hist.pop_front());
        m_prev = m_out;
        for (int c = 0; c < CH; c++) begin
          all_diff = (samp_hist.size() == STABLE);
          foreach (samp_hist[e]) if (samp_hist[e][c] == m_prev[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_out[c] = m_s[c];
            if (m_s[c]) m_rise[c] = 1'b1;
            else        m_fall[c] = 1'b1;
            if (m_s[c] != INIT) active_at[c] = sample_no;
          end else if ((m_prev[c] != INIT) && (sample_no - active_at[c] == LONG)) begin
            m_long[c] = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [CH-1:0] actual, input logic [CH-1:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_data_out", bus.data_out, m_out);
      checkOutput("model_rise", bus.rise, m_rise);
      checkOutput("model_fall", bus.fall, m_fall);
      checkOutput("model_long_press", bus.long_press, m_long);
    end
  end

  task automatic applyStimulus(input logic rst, input logic se, input logic [CH-1:0] din, input int cycles);
    reset         = rst;
    bus.sample_en = se;
    bus.data_in   = din;
    repeat (cycles) @(negedge clk);
  endtask

  // Counts negedges until the selected event shows on channel ch; -1 on timeout.
  task automatic waitEvent(input int kind, input int ch, input int budget, output int n);
    logic [CH-1:0] v;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      v = (kind == EV_RISE) ? bus.rise : (kind == EV_FALL) ? bus.fall : bus.long_press;
      if (v[ch]) break;
      if (n >= budget) begin
        n = -1;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int seen;
    logic [CH-1:0] din;

    // Reset held for three cycles with both inputs pressed
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 1);
      checkOutput("reset_data_out", bus.data_out, 2'b11);
      checkOutput("reset_pulses", bus.rise | bus.fall | bus.long_press, 2'b00);
    end
    applyStimulus(1'b0, 1'b1, 2'b11, 1);
    checkOutput("post_reset_data_out", bus.data_out, 2'b11);
    checkOutput("post_reset_pulses", bus.rise | bus.fall | bus.long_press, 2'b00);

    // Bounce on channel 0, ending released
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      din = {1'b1, i[0]};
      applyStimulus(1'b0, 1'b1, din, 1);
      if (bus.fall[0]) seen++;
    end
    applyStimulus(1'b0, 1'b1, 2'b11, 12);
    checkCount("bounce_no_fall", seen, 0);
    checkOutput("bounce_level", bus.data_out, 2'b11);

    // Clean press, long press, release, then a second press
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(1'b0, 1'b1, 2'b10, 0);
      waitEvent(EV_FALL, 0, 30, n);
      checkCount("press_latency", n, 10);
      checkOutput("press_level", bus.data_out, 2'b10);
      checkOutput("press_fall_vec", bus.fall, 2'b01);
      waitEvent(EV_LONG, 0, 40, n);
      checkCount("long_latency", n, 20);
      if (rep == 0) begin
        seen = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (bus.long_press[0]) seen++;
        end
        checkCount("long_no_repeat", seen, 0);
      end
      applyStimulus(1'b0, 1'b1, 2'b11, 0);
      waitEvent(EV_RISE, 0, 30, n);
      checkCount("release_latency", n, 10);
      checkOutput("release_level", bus.data_out, 2'b11);
    end

    // Strobe gating: one sampled edge in four, channel 1 pressed
    applyStimulus(1'b0, 1'b1, 2'b01, 0);
    n = -1;
    seen = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      bus.sample_en = (j % 4 == 0);
      if (bus.fall[1]) begin
        seen++;
        if (n < 0) n = j;
      end
    end
    checkCount("strobe_latency", n, 33);
    checkCount("strobe_single_fall", seen, 1);
    checkOutput("strobe_level", bus.data_out, 2'b01);
    applyStimulus(1'b0, 1'b1, 2'b11, 0);
    waitEvent(EV_RISE, 1, 30, n);
    checkCount("strobe_release_latency", n, 10);

    // Reset after five pending samples, then simultaneous press on both channels
    applyStimulus(1'b0, 1'b1, 2'b00, 7);
    checkOutput("midcount_no_fall_yet", bus.data_out, 2'b11);
    applyStimulus(1'b1, 1'b1, 2'b00, 1);
    checkOutput("midcount_reset_level", bus.data_out, 2'b11);
    checkOutput("midcount_reset_fall", bus.fall, 2'b00);
    applyStimulus(1'b0, 1'b1, 2'b00, 0);
    waitEvent(EV_FALL, 1, 30, n);
    checkCount("simul_fall_latency", n, 10);
    checkOutput("simul_fall_vec", bus.fall, 2'b11);
    applyStimulus(1'b0, 1'b1, 2'b11, 0);
    waitEvent(EV_RISE, 0, 30, n);
    checkCount("simul_rise_latency", n, 10);
    checkOutput("simul_rise_vec", bus.rise, 2'b11);
    applyStimulus(1'b0, 1'b1, 2'b11, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
